mips_data_bus: RTL and testbench

//   Responder for the single-cycle CPU's data-memory port (data_memory_a/we/wd/rd).

---
 rtl/mips_data_bus_pkg.sv | 39 +++
 rtl/mips_data_bus_sync_fifo.sv | 69 ++++++
 rtl/mips_data_bus.sv | 129 ++++++++++++
 tb/tb_mips_data_bus.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_data_bus_pkg.sv
// rtl/mips_data_bus_pkg.sv - shared MMIO offsets, STATUS bit positions and address decode
//
// Purpose: constants and the region decode used by mips_data_bus.
// Contents:
//   OFF_*          word offsets (a[3:2]) of the MMIO registers in the 16-byte window
//   STATUS_*_BIT   bit positions inside the STATUS register
//   region_e       decode result for one data-memory access
//   decode_region  RAM takes priority, then the MMIO window, everything else unmapped
package mips_data_bus_pkg;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_OVFCLR = 2'd3;

  localparam int STATUS_OVF_BIT   = 31;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_FULL_BIT  = 8;

  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'd0,
    REGION_RAM      = 2'd1,
    REGION_MMIO     = 2'd2
  } region_e;

  // mmio_tag is the base address with its low nibble dropped (the window is 16 bytes)
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [27:0] mmio_tag);
    region_e r;
    r = REGION_UNMAPPED;
    if (addr < ram_bytes)
      r = REGION_RAM;
    else if (addr[31:4] == mmio_tag)
      r = REGION_MMIO;
    return r;
  endfunction

endpackage

// File: rtl/mips_data_bus_sync_fifo.sv
// rtl/mips_data_bus_sync_fifo.sv - synchronous FIFO used as the TX byte queue
//
// Purpose: DEPTH-entry FIFO with registered storage and no write-to-read bypass.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (pointers and count only)
//   push   in   write din this edge; accepted when not full, or when full and popping
//   pop    in   consumer takes the head this edge (ignored while empty)
//   din    in   WIDTH-bit entry to push
//   dout   out  head entry, valid while !empty
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, wr_ptr == rd_ptr: the slot being overwritten is the head leaving this edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_data_bus.sv
// rtl/mips_data_bus.sv - data-memory responder: word RAM plus cycle counter / TX FIFO MMIO
//
// Purpose: answers the single-cycle CPU data port; decodes RAM, MMIO window, unmapped.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   data_memory_a   in   byte address, bits [1:0] ignored
//   data_memory_we  in   write enable, sampled at the rising edge
//   data_memory_wd  in   write data
//   data_memory_rd  out  read data, combinational from data_memory_a
//   tx_valid        out  TX FIFO not empty
//   tx_data         out  TX FIFO head byte
//   tx_ready        in   consumer takes the head on this edge
module mips_data_bus
  import mips_data_bus_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_memory_a,
  input  logic        data_memory_we,
  input  logic [31:0] data_memory_wd,
  output logic [31:0] data_memory_rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  region_e           region;
  logic [1:0]        reg_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_wr;
  logic              mmio_wr;
  logic              cycle_wr;
  logic              tx_push;
  logic              ovf_clr;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       cycle;
  logic              overflow;
  logic [31:0]       status;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign region   = decode_region(data_memory_a, RAM_BYTES, MMIO_BASE[31:4]);
  assign reg_off  = data_memory_a[3:2];
  assign ram_idx  = data_memory_a[RAM_AW+1:2];
  assign ram_wr   = data_memory_we && (region == REGION_RAM);
  assign mmio_wr  = data_memory_we && (region == REGION_MMIO);
  assign cycle_wr = mmio_wr && (reg_off == OFF_CYCLE);
  assign tx_push  = mmio_wr && (reg_off == OFF_TXDATA);
  assign ovf_clr  = mmio_wr && (reg_off == OFF_OVFCLR);

  // RAM contents survive reset; only the write port is clocked.
  always_ff @(posedge clk) begin
    if (ram_wr)
      ram[ram_idx] <= data_memory_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle <= '0;
    else if (cycle_wr)
      cycle <= data_memory_wd;
    else
      cycle <= cycle + 32'd1;
  end

  // A push into a full FIFO is only lost when no pop frees a slot on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (ovf_clr)
      overflow <= 1'b0;
    else if (tx_push && fifo_full && !(tx_valid && tx_ready))
      overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (data_memory_wd[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Empty comes straight from the async-reset count, so tx_valid drops with reset.
  assign tx_valid = !fifo_empty;

  always_comb begin
    status                   = '0;
    status[STATUS_OVF_BIT]   = overflow;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[7:0]              = 8'(fifo_count);
  end

  always_comb begin
    data_memory_rd = '0;
    case (region)
      REGION_RAM: data_memory_rd = ram[ram_idx];
      REGION_MMIO: begin
        case (reg_off)
          OFF_CYCLE:  data_memory_rd = cycle;
          OFF_STATUS: data_memory_rd = status;
          default:    data_memory_rd = '0;
        endcase
      end
      default: data_memory_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_data_bus.sv
// tb/tb_mips_data_bus.sv - self-checking bench for mips_data_bus
module tb_mips_data_bus;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] A_CYCLE = 32'hFFFF0000;
  localparam logic [31:0] A_TXD   = 32'hFFFF0004;
  localparam logic [31:0] A_STAT  = 32'hFFFF0008;
  localparam logic [31:0] A_OVFC  = 32'hFFFF000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_memory_a = '0;
  logic        data_memory_we = 1'b0;
  logic [31:0] data_memory_wd = '0;
  logic [31:0] data_memory_rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  mips_data_bus dut (
    .clk            (clk),
    .reset          (reset),
    .data_memory_a  (data_memory_a),
    .data_memory_we (data_memory_we),
    .data_memory_wd (data_memory_wd),
    .data_memory_rd (data_memory_rd),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    data_memory_a  = addr;
    data_memory_wd = data;
    data_memory_we = 1'b1;
    step();
    data_memory_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    data_memory_we = 1'b0;
    data_memory_a  = addr;
    #1;
    data = data_memory_rd;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) step();
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
    end
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h200) begin
      fails++; $display("FAIL reset_status: got %h expected 00000200", d);
    end
    bus_read(A_CYCLE, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL reset_cycle: got %h expected 0", d);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h10, 32'h11111111);
    data_memory_a  = 32'h10;
    data_memory_wd = 32'h12345678;
    data_memory_we = 1'b1;
    #1;
    tests++;
    if (data_memory_rd !== 32'h11111111) begin
      fails++; $display("FAIL ram_old_before_edge: got %h expected 11111111", data_memory_rd);
    end
    step();
    data_memory_we = 1'b0;
    bus_read(32'h10, d);
    tests++;
    if (d !== 32'h12345678) begin
      fails++; $display("FAIL ram_store_load: got %h expected 12345678", d);
    end
    bus_read(32'h13, d);
    tests++;
    if (d !== 32'h12345678) begin
      fails++; $display("FAIL ram_low_bits_ignored: got %h expected 12345678", d);
    end
    bus_write(32'h80000000, 32'hDEADBEEF);
    bus_read(32'h80000000, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL unmapped_read: got %h expected 0", d);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] d;
    bus_write(A_CYCLE, 32'h0);
    repeat (5) step();
    bus_read(A_CYCLE, d);
    tests++;
    if (d !== 32'd5) begin
      fails++; $display("FAIL cycle_count5: got %h expected 5", d);
    end
    bus_write(A_CYCLE, 32'hFFFFFFFF);
    bus_read(A_CYCLE, d);
    tests++;
    if (d !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL cycle_load: got %h expected ffffffff", d);
    end
    step();
    bus_read(A_CYCLE, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL cycle_wrap: got %h expected 0", d);
    end
  endtask

  task automatic test_fifo_drain();
    logic [31:0] d;
    tx_ready       = 1'b0;
    data_memory_a  = A_TXD;
    data_memory_wd = 32'h41;
    data_memory_we = 1'b1;
    #1;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL no_bypass: got %b expected 0", tx_valid);
    end
    step();
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      fails++; $display("FAIL push_latency: got %b/%h expected 1/41", tx_valid, tx_data);
    end
    data_memory_wd = 32'h42; step();
    data_memory_wd = 32'h43; step();
    data_memory_we = 1'b0;
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h003) begin
      fails++; $display("FAIL status_three: got %h expected 00000003", d);
    end
    step(); step();
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      fails++; $display("FAIL head_held: got %b/%h expected 1/41", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        fails++; $display("FAIL drain_byte%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step();
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL drain_empty: got %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h200) begin
      fails++; $display("FAIL drain_status: got %h expected 00000200", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(A_TXD, 32'(32'h60 + i));
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h80000108) begin
      fails++; $display("FAIL ovf_status: got %h expected 80000108", d);
    end
    bus_write(A_OVFC, 32'h0);
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h108) begin
      fails++; $display("FAIL ovf_clear: got %h expected 00000108", d);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h60 + i)) begin
        fails++; $display("FAIL ovf_drain%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, 8'(8'h60 + i));
      end
      step();
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL ovf_ninth_dropped: got valid %b data %h expected empty", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(A_TXD, 32'(32'h70 + i));
    tx_ready = 1'b1;
    bus_write(A_TXD, 32'h55);
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h108) begin
      fails++; $display("FAIL full_push_pop_status: got %h expected 00000108", d);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [7:0] e;
      e = (i == DEPTH) ? 8'h55 : 8'(8'h70 + i);
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        fails++; $display("FAIL full_push_pop_order%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, e);
      end
      step();
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL full_push_pop_empty: got %b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(32'h20, 32'hCAFEF00D);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_TXD, 32'(32'hA0 + i));
    tx_ready = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset_valid: got %b expected 0", tx_valid);
    end
    reset = 1'b0;
    bus_read(A_STAT, d);
    tests++;
    if (d !== 32'h200) begin
      fails++; $display("FAIL async_reset_status: got %h expected 00000200", d);
    end
    bus_read(A_CYCLE, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL async_reset_cycle: got %h expected 0", d);
    end
    bus_read(32'h20, d);
    tests++;
    if (d !== 32'hCAFEF00D) begin
      fails++; $display("FAIL async_reset_ram_kept: got %h expected cafef00d", d);
    end
    tx_ready = 1'b0;
    step();
  endtask

  // Reference model: byte queue, sticky flag, counter value, RAM word map.
  task automatic test_random();
    logic [7:0]  q[$];
    logic [31:0] ram_m [16];
    logic [31:0] cyc_m;
    logic        ovf_m;
    logic [31:0] exp_rd;
    int          op;
    logic        cyc_wr, push, clr, ram_wr;
    int          widx;

    for (int i = 0; i < 16; i++) begin
      ram_m[i] = $urandom;
      bus_write(32'(i * 4), ram_m[i]);
    end
    cyc_m = $urandom;
    bus_write(A_CYCLE, cyc_m);
    ovf_m = 1'b0;

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      widx = $urandom_range(0, 15);
      tx_ready = ($urandom_range(0, 2) == 0);
      data_memory_wd = $urandom;
      data_memory_we = 1'b0;
      case (op)
        0, 1, 2: begin data_memory_a = 32'(widx * 4 + $urandom_range(0, 3)); data_memory_we = 1'b1; end
        3, 4:    data_memory_a = 32'(widx * 4 + $urandom_range(0, 3));
        5:       begin data_memory_a = A_TXD; data_memory_we = 1'b1; end
        6:       begin data_memory_a = A_STAT; data_memory_we = ($urandom_range(0, 3) == 0); end
        7:       begin data_memory_a = A_CYCLE; data_memory_we = ($urandom_range(0, 3) == 0); end
        8:       begin data_memory_a = A_OVFC; data_memory_we = ($urandom_range(0, 1) == 0); end
        default: begin data_memory_a = 32'h40000000 | 32'($urandom_range(0, 65535)); data_memory_we = $urandom_range(0, 1); end
      endcase

      if (op <= 4)       exp_rd = ram_m[widx];
      else if (op == 6)  exp_rd = {ovf_m, 21'd0, (q.size() == 0), (q.size() == DEPTH), 8'(q.size())};
      else if (op == 7)  exp_rd = cyc_m;
      else               exp_rd = 32'h0;

      #1;
      tests++;
      if (data_memory_rd !== exp_rd) begin
        fails++; $display("FAIL rand_rd[%0d] a=%h: got %h expected %h", n, data_memory_a, data_memory_rd, exp_rd);
      end
      tests++;
      if (tx_valid !== (q.size() != 0)) begin
        fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, tx_valid, (q.size() != 0));
      end
      if (q.size() != 0) begin
        tests++;
        if (tx_data !== q[0]) begin
          fails++; $display("FAIL rand_data[%0d]: got %h expected %h", n, tx_data, q[0]);
        end
      end

      ram_wr = data_memory_we && (op <= 2);
      push   = data_memory_we && (op == 5);
      cyc_wr = data_memory_we && (op == 7);
      clr    = data_memory_we && (op == 8);

      step();

      if (tx_ready && q.size() != 0) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(data_memory_wd[7:0]);
        else ovf_m = 1'b1;
      end
      if (clr) ovf_m = 1'b0;
      if (ram_wr) ram_m[widx] = data_memory_wd;
      cyc_m = cyc_wr ? data_memory_wd : cyc_m + 32'd1;
    end
    data_memory_we = 1'b0;
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_fifo_drain();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
